ram_sp_arb: RTL and testbench

Single-port RAM access arbiter and read-return buffer. Merges a write-request stream and a read-request stream onto the one shared address/port of a single-port RAM instance built with registered output (1-cycle read latency). Returns read data on a valid/ready stream through a 3-entry buffer, so a stalled consumer never loses RAM output. Sits directly in front of the single-port RAM, between the RAM and the client logic.

---
 rtl/ram_sp_arb_if.sv | 42 ++++
 rtl/ram_sp_arb.sv | 94 +++++++++
 tb/tb_ram_sp_arb.sv | 300 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ram_sp_arb_if.sv
// Client and RAM-side signals of the single-port RAM arbiter.
// The slave modport is the arbiter's view; the master modport is the surrounding logic's view.
interface ram_sp_arb_if #(
    parameter int D_WIDTH = 32,
    parameter int D_DEPTH = 64,
    parameter bit BYTE_EN = 1'b0
);
    localparam int AW   = $clog2(D_DEPTH);
    localparam int BE_W = BYTE_EN ? D_WIDTH / 8 : 1;

    logic                wr_valid_i;
    logic                wr_ready_o;
    logic [AW-1:0]       wr_addr_i;
    logic [D_WIDTH-1:0]  wr_data_i;
    logic [BE_W-1:0]     wr_byteen_i;
    logic                rd_req_valid_i;
    logic                rd_req_ready_o;
    logic [AW-1:0]       rd_addr_i;
    logic                rd_valid_o;
    logic                rd_ready_i;
    logic [D_WIDTH-1:0]  rd_data_o;
    logic                ram_wr_en_o;
    logic [D_WIDTH-1:0]  ram_wr_data_o;
    logic [BE_W-1:0]     ram_wr_byteen_o;
    logic [AW-1:0]       ram_rw_addr_o;
    logic                ram_rd_en_o;
    logic [D_WIDTH-1:0]  ram_rd_data_i;

    modport slave (
        input  wr_valid_i, wr_addr_i, wr_data_i, wr_byteen_i,
        input  rd_req_valid_i, rd_addr_i, rd_ready_i, ram_rd_data_i,
        output wr_ready_o, rd_req_ready_o, rd_valid_o, rd_data_o,
        output ram_wr_en_o, ram_wr_data_o, ram_wr_byteen_o, ram_rw_addr_o, ram_rd_en_o
    );

    modport master (
        output wr_valid_i, wr_addr_i, wr_data_i, wr_byteen_i,
        output rd_req_valid_i, rd_addr_i, rd_ready_i, ram_rd_data_i,
        input  wr_ready_o, rd_req_ready_o, rd_valid_o, rd_data_o,
        input  ram_wr_en_o, ram_wr_data_o, ram_wr_byteen_o, ram_rw_addr_o, ram_rd_en_o
    );
endinterface

// File: rtl/ram_sp_arb.sv
// Arbitrates write and read requests onto one single-port RAM (1-cycle registered read)
// and returns read data through a 3-entry buffer guarded by a read credit counter.
module ram_sp_arb #(
    parameter int D_WIDTH = 32,
    parameter int D_DEPTH = 64,
    parameter bit BYTE_EN = 1'b0
) (
    input  logic        clk_i,
    input  logic        rst_i,
    ram_sp_arb_if.slave bus
);
    localparam int AW = $clog2(D_DEPTH);

    logic [1:0]         cnt_q, cnt_d;
    logic [1:0]         occ_q, occ_d;
    logic [1:0]         wr_ptr_q, wr_ptr_d;
    logic [1:0]         rd_ptr_q, rd_ptr_d;
    logic               pend_q, pend_d;
    logic               last_wr_q, last_wr_d;
    logic [AW-1:0]      addr_q, addr_d;
    logic [D_WIDTH-1:0] buf_q [3];
    logic [D_WIDTH-1:0] buf_d [3];

    logic wr_elig, rd_elig, gnt_wr, gnt_rd, pop;

    function automatic logic [1:0] ptr_inc(input logic [1:0] p);
        return (p == 2'd2) ? 2'd0 : p + 2'd1;
    endfunction

    // Grants are gated by reset so nothing reaches the RAM while rst_i is high.
    always_comb begin
        wr_elig = bus.wr_valid_i;
        rd_elig = bus.rd_req_valid_i && (cnt_q != 2'd3);
        gnt_wr  = !rst_i && wr_elig && (!rd_elig || !last_wr_q);
        gnt_rd  = !rst_i && rd_elig && !gnt_wr;
        pop     = (occ_q != 2'd0) && bus.rd_ready_i;
    end

    always_comb begin
        cnt_d     = cnt_q + {1'b0, gnt_rd} - {1'b0, pop};
        occ_d     = occ_q + {1'b0, pend_q} - {1'b0, pop};
        pend_d    = gnt_rd;
        wr_ptr_d  = pend_q ? ptr_inc(wr_ptr_q) : wr_ptr_q;
        rd_ptr_d  = pop ? ptr_inc(rd_ptr_q) : rd_ptr_q;
        last_wr_d = last_wr_q;
        addr_d    = addr_q;
        if (gnt_wr) begin
            last_wr_d = 1'b1;
            addr_d    = bus.wr_addr_i;
        end else if (gnt_rd) begin
            last_wr_d = 1'b0;
            addr_d    = bus.rd_addr_i;
        end
        buf_d = buf_q;
        if (pend_q) buf_d[wr_ptr_q] = bus.ram_rd_data_i;
    end

    always_comb begin
        bus.wr_ready_o      = gnt_wr;
        bus.rd_req_ready_o  = gnt_rd;
        bus.ram_wr_en_o     = gnt_wr;
        bus.ram_rd_en_o     = gnt_rd;
        bus.ram_rw_addr_o   = addr_d;
        bus.ram_wr_data_o   = bus.wr_data_i;
        bus.ram_wr_byteen_o = BYTE_EN ? bus.wr_byteen_i : '1;
        bus.rd_valid_o      = (occ_q != 2'd0);
        bus.rd_data_o       = (occ_q != 2'd0) ? buf_q[rd_ptr_q] : '0;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q     <= '0;
            occ_q     <= '0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            pend_q    <= 1'b0;
            last_wr_q <= 1'b0;
            addr_q    <= '0;
        end else begin
            cnt_q     <= cnt_d;
            occ_q     <= occ_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            pend_q    <= pend_d;
            last_wr_q <= last_wr_d;
            addr_q    <= addr_d;
        end
    end

    // Buffer payload needs no reset: it is only visible while occupancy is non-zero.
    always_ff @(posedge clk_i) begin
        buf_q <= buf_d;
    end
endmodule

// File: tb/tb_ram_sp_arb.sv
// Bench for ram_sp_arb: behavioural RAMs plus a queue-based reference model of grants and read returns.
module tb_ram_sp_arb;
    localparam int DW = 32;
    localparam int DD = 64;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    ram_sp_arb_if #(.D_WIDTH(DW), .D_DEPTH(DD), .BYTE_EN(1'b0)) bus0 ();
    ram_sp_arb_if #(.D_WIDTH(DW), .D_DEPTH(DD), .BYTE_EN(1'b1)) bus1 ();

    ram_sp_arb #(.D_WIDTH(DW), .D_DEPTH(DD), .BYTE_EN(1'b0)) dut0 (.clk_i(clk), .rst_i(rst), .bus(bus0));
    ram_sp_arb #(.D_WIDTH(DW), .D_DEPTH(DD), .BYTE_EN(1'b1)) dut1 (.clk_i(clk), .rst_i(rst), .bus(bus1));

    // Behavioural single-port RAMs with registered read output
    logic [DW-1:0] ram0 [DD];
    logic [DW-1:0] ram0_q;
    logic [DW-1:0] ram1 [DD];
    logic [DW-1:0] ram1_q;

    always @(posedge clk) begin
        if (bus0.ram_wr_en_o) ram0[bus0.ram_rw_addr_o] <= bus0.ram_wr_data_o;
        if (bus0.ram_rd_en_o) ram0_q <= ram0[bus0.ram_rw_addr_o];
    end
    assign bus0.ram_rd_data_i = ram0_q;

    always @(posedge clk) begin
        if (bus1.ram_wr_en_o)
            for (int b = 0; b < 4; b++)
                if (bus1.ram_wr_byteen_o[b]) ram1[bus1.ram_rw_addr_o][8*b +: 8] <= bus1.ram_wr_data_o[8*b +: 8];
        if (bus1.ram_rd_en_o) ram1_q <= ram1[bus1.ram_rw_addr_o];
    end
    assign bus1.ram_rd_data_i = ram1_q;

    // Reference model: memory image, queue of outstanding reads (data + cycle it becomes visible)
    logic [DW-1:0] mdl_mem [DD];
    logic [DW-1:0] q_data [$];
    int            q_avail [$];
    bit            last_wr;
    int            cyc;
    bit            g_w, g_r;

    int n_tot  = 0;
    int n_pass = 0;

    task automatic chk1(input string tag, input logic obs, input logic exp);
        n_tot++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic chkw(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tot++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic cyc_check();
        bit wel, rel, exp_v, pop;
        @(negedge clk);
        wel = bus0.wr_valid_i;
        rel = bus0.rd_req_valid_i && (q_data.size() < 3);
        g_w = wel && (!rel || !last_wr);
        g_r = rel && !g_w;
        chk1("wr_ready", bus0.wr_ready_o, g_w);
        chk1("rd_req_ready", bus0.rd_req_ready_o, g_r);
        chk1("ram_wr_en", bus0.ram_wr_en_o, g_w);
        chk1("ram_rd_en", bus0.ram_rd_en_o, g_r);
        if (g_w) begin
            chkw("ram_addr_w", 32'(bus0.ram_rw_addr_o), 32'(bus0.wr_addr_i));
            chkw("ram_wdata", bus0.ram_wr_data_o, bus0.wr_data_i);
            chk1("ram_byteen", bus0.ram_wr_byteen_o, 1'b1);
        end
        if (g_r) chkw("ram_addr_r", 32'(bus0.ram_rw_addr_o), 32'(bus0.rd_addr_i));
        exp_v = (q_data.size() > 0) && (q_avail[0] <= cyc);
        chk1("rd_valid", bus0.rd_valid_o, exp_v);
        if (exp_v) chkw("rd_data", bus0.rd_data_o, q_data[0]);
        pop = exp_v && bus0.rd_ready_i;
        if (pop) begin
            void'(q_data.pop_front());
            void'(q_avail.pop_front());
        end
        if (g_w) begin
            mdl_mem[bus0.wr_addr_i] = bus0.wr_data_i;
            last_wr = 1'b1;
        end
        if (g_r) begin
            q_data.push_back(mdl_mem[bus0.rd_addr_i]);
            q_avail.push_back(cyc + 2);
            last_wr = 1'b0;
        end
    endtask

    task automatic cyc_edge();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic step();
        cyc_check();
        cyc_edge();
    endtask

    task automatic rst_outs(input string tag);
        chk1({tag, "_wr_ready"}, bus0.wr_ready_o, 1'b0);
        chk1({tag, "_rd_req_ready"}, bus0.rd_req_ready_o, 1'b0);
        chk1({tag, "_rd_valid"}, bus0.rd_valid_o, 1'b0);
        chk1({tag, "_ram_wr_en"}, bus0.ram_wr_en_o, 1'b0);
        chk1({tag, "_ram_rd_en"}, bus0.ram_rd_en_o, 1'b0);
        chkw({tag, "_rd_data"}, bus0.rd_data_o, 32'h0);
        chkw({tag, "_ram_addr"}, 32'(bus0.ram_rw_addr_o), 32'h0);
    endtask

    task automatic rst_cycle(input string tag);
        @(negedge clk);
        rst_outs(tag);
        @(posedge clk);
        #1;
        cyc++;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int idx, nv, ng, npop;
        logic [5:0] pat;
        logic [DW-1:0] fr_exp;

        bus0.wr_valid_i = 1'b0; bus0.wr_addr_i = '0; bus0.wr_data_i = '0; bus0.wr_byteen_i = '0;
        bus0.rd_req_valid_i = 1'b0; bus0.rd_addr_i = '0; bus0.rd_ready_i = 1'b0;
        bus1.wr_valid_i = 1'b0; bus1.wr_addr_i = '0; bus1.wr_data_i = '0; bus1.wr_byteen_i = '0;
        bus1.rd_req_valid_i = 1'b0; bus1.rd_addr_i = '0; bus1.rd_ready_i = 1'b0;
        cyc = 0;
        last_wr = 1'b0;

        // Power-on reset, then idle cycle after release
        rst_cycle("por");
        rst_cycle("por");
        rst = 1'b0;
        rst_cycle("post_rel");
        chk1("dut1_rst_valid", bus1.rd_valid_o, 1'b0);

        // Fill the whole RAM through the arbiter
        bus0.rd_ready_i = 1'b1;
        for (int i = 0; i < DD; i++) begin
            bus0.wr_valid_i = 1'b1;
            bus0.wr_addr_i  = 6'(i);
            bus0.wr_data_i  = $urandom;
            step();
        end
        bus0.wr_valid_i = 1'b0;

        // Write then read back address 5 with exact latency
        bus0.wr_valid_i = 1'b1; bus0.wr_addr_i = 6'd5; bus0.wr_data_i = 32'hDEADBEEF;
        step();
        bus0.wr_valid_i = 1'b0;
        bus0.rd_req_valid_i = 1'b1; bus0.rd_addr_i = 6'd5;
        cyc_check();
        chk1("rdlat_grant", bus0.rd_req_ready_o, 1'b1);
        cyc_edge();
        bus0.rd_req_valid_i = 1'b0;
        cyc_check();
        chk1("rdlat_t1_valid", bus0.rd_valid_o, 1'b0);
        cyc_edge();
        cyc_check();
        chk1("rdlat_t2_valid", bus0.rd_valid_o, 1'b1);
        chkw("rdlat_data", bus0.rd_data_o, 32'hDEADBEEF);
        cyc_edge();

        // Back-pressure: five reads of 0..4 with consumer stalled
        bus0.rd_ready_i = 1'b0;
        idx = 0;
        repeat (8) begin
            bus0.rd_req_valid_i = (idx < 5);
            bus0.rd_addr_i = 6'(idx);
            cyc_check();
            if (bus0.rd_req_ready_o) idx++;
            cyc_edge();
        end
        chkw("bp_grants", 32'(idx), 32'd3);
        bus0.rd_ready_i = 1'b1;
        npop = 0;
        for (int k = 0; k < 40 && !(idx == 5 && npop == 5); k++) begin
            bus0.rd_req_valid_i = (idx < 5);
            bus0.rd_addr_i = 6'(idx);
            cyc_check();
            if (bus0.rd_req_ready_o) idx++;
            if (bus0.rd_valid_o) npop++;
            cyc_edge();
        end
        bus0.rd_req_valid_i = 1'b0;
        chkw("bp_returned", 32'(npop), 32'd5);

        // Streaming reads: one datum per cycle after the initial latency
        nv = 0; ng = 0;
        for (int k = 0; k < 20; k++) begin
            bus0.rd_req_valid_i = 1'b1;
            bus0.rd_addr_i = 6'($urandom_range(0, DD - 1));
            cyc_check();
            if (bus0.rd_req_ready_o) ng++;
            if (k >= 2 && bus0.rd_valid_o) nv++;
            cyc_edge();
        end
        bus0.rd_req_valid_i = 1'b0;
        chkw("stream_grants", 32'(ng), 32'd20);
        chkw("stream_valids", 32'(nv), 32'd18);
        repeat (4) step();

        // Reset with one entry buffered and reads still in flight
        bus0.rd_ready_i = 1'b0;
        bus0.rd_req_valid_i = 1'b1;
        bus0.rd_addr_i = 6'($urandom_range(0, DD - 1)); step();
        bus0.rd_addr_i = 6'($urandom_range(0, DD - 1)); step();
        bus0.rd_addr_i = 6'($urandom_range(0, DD - 1)); cyc_check();
        #1 rst = 1'b1;
        #1 rst_outs("mid_rst");
        q_data.delete();
        q_avail.delete();
        last_wr = 1'b0;
        bus0.wr_valid_i = 1'b1;
        @(posedge clk); #1; cyc++;
        rst_cycle("in_rst");
        rst_cycle("in_rst");
        rst = 1'b0;

        // Both requesters active right after reset: W,R,W,R,W,R
        bus0.rd_ready_i = 1'b1;
        pat = 6'b101010;
        fr_exp = '0;
        for (int i = 0; i < 6; i++) begin
            bus0.wr_valid_i = 1'b1;
            bus0.rd_req_valid_i = 1'b1;
            bus0.wr_addr_i = 6'($urandom_range(0, 7));
            bus0.wr_data_i = $urandom;
            bus0.rd_addr_i = 6'($urandom_range(0, 7));
            cyc_check();
            if (i == 1) fr_exp = mdl_mem[bus0.rd_addr_i];
            chk1("alt_w", bus0.wr_ready_o, pat[5-i]);
            chk1("alt_r", bus0.rd_req_ready_o, ~pat[5-i]);
            if (i == 3) begin
                chk1("post_rst_first_valid", bus0.rd_valid_o, 1'b1);
                chkw("post_rst_first_data", bus0.rd_data_o, fr_exp);
            end
            cyc_edge();
        end
        bus0.wr_valid_i = 1'b0;
        bus0.rd_req_valid_i = 1'b0;
        repeat (4) step();

        // Randomised traffic on a small address window for frequent collisions
        for (int k = 0; k < 1500; k++) begin
            bus0.wr_valid_i = ($urandom_range(0, 2) != 0);
            bus0.rd_req_valid_i = ($urandom_range(0, 3) != 0);
            bus0.rd_ready_i = ($urandom_range(0, 2) != 0);
            bus0.wr_addr_i = 6'($urandom_range(0, 7));
            bus0.wr_data_i = $urandom;
            bus0.rd_addr_i = 6'($urandom_range(0, 7));
            step();
        end
        bus0.wr_valid_i = 1'b0;
        bus0.rd_req_valid_i = 1'b0;
        bus0.rd_ready_i = 1'b1;
        repeat (6) step();
        chk1("drain_empty", bus0.rd_valid_o, 1'b0);

        // Byte-enable instance: merged writes then readback
        bus1.rd_ready_i = 1'b1;
        bus1.wr_valid_i = 1'b1; bus1.wr_addr_i = 6'd3; bus1.wr_data_i = 32'h11223344; bus1.wr_byteen_i = 4'hF;
        @(negedge clk); chk1("be_w1_ready", bus1.wr_ready_o, 1'b1); @(posedge clk); #1;
        bus1.wr_data_i = 32'hAABBCCDD; bus1.wr_byteen_i = 4'b0101;
        @(negedge clk); chk1("be_w2_ready", bus1.wr_ready_o, 1'b1);
        chkw("be_w2_byteen", 32'(bus1.ram_wr_byteen_o), 32'h5); @(posedge clk); #1;
        bus1.wr_valid_i = 1'b0;
        bus1.rd_req_valid_i = 1'b1; bus1.rd_addr_i = 6'd3;
        @(negedge clk); chk1("be_r1_ready", bus1.rd_req_ready_o, 1'b1); @(posedge clk); #1;
        bus1.rd_req_valid_i = 1'b0;
        @(negedge clk); chk1("be_r1_t1_valid", bus1.rd_valid_o, 1'b0); @(posedge clk); #1;
        @(negedge clk); chk1("be_r1_valid", bus1.rd_valid_o, 1'b1);
        chkw("be_r1_data", bus1.rd_data_o, 32'h11BB33DD); @(posedge clk); #1;
        bus1.wr_valid_i = 1'b1; bus1.wr_data_i = 32'h99000000; bus1.wr_byteen_i = 4'b1000;
        @(negedge clk); chk1("be_w3_ready", bus1.wr_ready_o, 1'b1); @(posedge clk); #1;
        bus1.wr_valid_i = 1'b0;
        bus1.rd_req_valid_i = 1'b1;
        @(negedge clk); chk1("be_r2_ready", bus1.rd_req_ready_o, 1'b1); @(posedge clk); #1;
        bus1.rd_req_valid_i = 1'b0;
        @(posedge clk); #1;
        @(negedge clk); chk1("be_r2_valid", bus1.rd_valid_o, 1'b1);
        chkw("be_r2_data", bus1.rd_data_o, 32'h99BB33DD); @(posedge clk); #1;
        @(negedge clk); chk1("be_r2_popped", bus1.rd_valid_o, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end
endmodule
